cdda_stream_buffer: RTL

CDDA_STREAM_BUFFER -- requirements
Module: cdda_stream_buffer

---
 rtl/cdda_stream_buffer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/cdda_stream_buffer.sv
// CD-audio stream buffer: CPU/DMA-filled stereo frame ring with a read pointer
// advanced by the sound output, underflow/low-water interrupt and CPU register file.
module cdda_stream_buffer #(
    parameter int DEPTH_LOG2    = 8,
    parameter int CLK_FREQUENCY = 33868800
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DEPTH_LOG2+2:0] sram_a,
    input  logic [7:0]            sram_d_in,
    output logic [7:0]            sram_d_out,
    input  logic                  sram_cs,
    input  logic                  sram_oe,
    input  logic                  sram_we,
    output logic                  sram_wait,
    input  logic [7:0]            sdcard_dma_data,
    input  logic [8:0]            sdcard_dma_addr,
    input  logic                  sdcard_dma_strobe,
    input  logic                  consume,
    output logic                  dso_enabled,
    output logic [15:0]           left,
    output logic [15:0]           right,
    output logic                  irq
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int BW    = DEPTH_LOG2 + 2;
    localparam int AW    = DEPTH_LOG2 + 3;
    localparam logic [2:0] PAGE_MASK = 3'((1 << (DEPTH_LOG2 - 7)) - 1);

    if (DEPTH_LOG2 < 7 || DEPTH_LOG2 > 10 || CLK_FREQUENCY < 1) begin : g_param_check
        $error("cdda_stream_buffer: DEPTH_LOG2 must be 7..10 and CLK_FREQUENCY positive");
    end

    typedef logic [DEPTH_LOG2-1:0] ptr_t;

    function automatic ptr_t put_byte(ptr_t cur, logic hi, logic [7:0] d);
        logic [15:0] w;
        w = 16'(cur);
        if (hi) w[15:8] = d;
        else    w[7:0]  = d;
        return w[DEPTH_LOG2-1:0];
    endfunction

    function automatic logic [7:0] get_byte(ptr_t cur, logic hi);
        logic [15:0] w;
        w = 16'(cur);
        return hi ? w[15:8] : w[7:0];
    endfunction

    logic       enable, dma_mode, loop_en, irq_en;
    logic [2:0] dma_page;
    logic       underflow, irq_pending, dso_q;
    ptr_t       rdpos, last, lowater;

    logic [3:0][7:0] mem [DEPTH];
    logic [3:0][7:0] frame_q;

    logic       cpu_wr, reg_wr, unused_ok;
    logic [2:0] reg_sel;
    assign cpu_wr    = sram_cs & sram_we;
    assign reg_wr    = cpu_wr & ~sram_a[AW-1];
    assign reg_sel   = sram_a[4:2];
    assign unused_ok = sram_oe;

    // Single buffer write port: DMA owns it in dma_mode, the CPU otherwise.
    logic          buf_we;
    logic [BW-1:0] buf_addr;
    logic [7:0]    buf_data;
    always_comb begin
        buf_we   = cpu_wr & sram_a[AW-1];
        buf_addr = sram_a[BW-1:0];
        buf_data = sram_d_in;
        if (dma_mode) begin
            buf_we   = sdcard_dma_strobe;
            buf_addr = BW'({dma_page, sdcard_dma_addr});
            buf_data = sdcard_dma_data;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) mem[buf_addr[BW-1:2]][buf_addr[1:0]] <= buf_data;
        frame_q <= mem[rdpos];
    end

    ptr_t adv, rdpos_n, last_n, lowater_n;
    logic uf_set, irq_set, uf_n, pend_n, dso_n;
    always_comb begin
        adv     = rdpos;
        uf_set  = 1'b0;
        irq_set = 1'b0;
        if (enable && consume) begin
            if (rdpos != last)  adv = rdpos + ptr_t'(1);
            else if (loop_en)   adv = '0;
            else begin
                uf_set  = 1'b1;
                irq_set = 1'b1;
            end
            if (!uf_set && ptr_t'(last - adv) == lowater) irq_set = 1'b1;
        end

        rdpos_n   = adv;
        last_n    = last;
        lowater_n = lowater;
        uf_n      = underflow | uf_set;
        pend_n    = irq_pending;
        if (reg_wr) begin
            case (reg_sel)
                3'd1: begin
                    uf_n   = uf_n & ~sram_d_in[0];
                    pend_n = pend_n & ~sram_d_in[1];
                end
                3'd2: rdpos_n   = put_byte(rdpos, 1'b0, sram_d_in);
                3'd3: rdpos_n   = put_byte(rdpos, 1'b1, sram_d_in);
                3'd4: last_n    = put_byte(last, 1'b0, sram_d_in);
                3'd5: last_n    = put_byte(last, 1'b1, sram_d_in);
                3'd6: lowater_n = put_byte(lowater, 1'b0, sram_d_in);
                3'd7: lowater_n = put_byte(lowater, 1'b1, sram_d_in);
                default: ;
            endcase
        end
        // A new interrupt beats a same-cycle acknowledge.
        pend_n = pend_n | irq_set;

        // Once disabled, keep the output alive until the current frame is consumed.
        dso_n = dso_q;
        if (enable)       dso_n = 1'b1;
        else if (consume) dso_n = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable      <= 1'b0;
            dma_mode    <= 1'b0;
            loop_en     <= 1'b0;
            irq_en      <= 1'b0;
            dma_page    <= '0;
            underflow   <= 1'b0;
            irq_pending <= 1'b0;
            dso_q       <= 1'b0;
            rdpos       <= '0;
            last        <= '0;
            lowater     <= '0;
        end else begin
            if (reg_wr && reg_sel == 3'd0) begin
                enable   <= sram_d_in[0];
                dma_mode <= sram_d_in[2];
                loop_en  <= sram_d_in[3];
                irq_en   <= sram_d_in[4];
                dma_page <= sram_d_in[7:5] & PAGE_MASK;
            end
            underflow   <= uf_n;
            irq_pending <= pend_n;
            dso_q       <= dso_n;
            rdpos       <= rdpos_n;
            last        <= last_n;
            lowater     <= lowater_n;
        end
    end

    always_comb begin
        sram_d_out = 8'h00;
        if (!sram_a[AW-1]) begin
            case (reg_sel)
                3'd0: sram_d_out = {dma_page, irq_en, loop_en, dma_mode, 1'b0, enable};
                3'd1: sram_d_out = {6'd0, irq_pending, underflow};
                3'd2: sram_d_out = get_byte(rdpos, 1'b0);
                3'd3: sram_d_out = get_byte(rdpos, 1'b1);
                3'd4: sram_d_out = get_byte(last, 1'b0);
                3'd5: sram_d_out = get_byte(last, 1'b1);
                3'd6: sram_d_out = get_byte(lowater, 1'b0);
                default: sram_d_out = get_byte(lowater, 1'b1);
            endcase
        end
    end

    logic mute;
    assign mute        = underflow | ~dso_q;
    assign left        = mute ? 16'h0000 : {frame_q[1], frame_q[0]};
    assign right       = mute ? 16'h0000 : {frame_q[3], frame_q[2]};
    assign dso_enabled = dso_q;
    assign irq         = irq_pending & irq_en;
    assign sram_wait   = 1'b0;
endmodule
